pipe_stage_regs: RTL and testbench
==================================

PIPE_STAGE_REGS -- requirements
Module: pipe_stage_regs

Interface
REQ-001 The block SHALL have parameter DATA_W, default 32: payload width, held on flush.
REQ-002 The block SHALL have parameter CTRL_W, default 8: control-field width, zeroed on flush and reset.
REQ-003 The block SHALL have parameter DEPTH, default 1, legal 1..4: number of register stages.
REQ-004 The block SHALL have port clk, input, 1: clock, rising edge.
REQ-005 The block SHALL have port rst_n, input, 1: reset, asynchronous, active-low.
REQ-006 The block SHALL have port in_valid, input, 1: upstream holds a valid beat.
REQ-007 The block SHALL have port in_ready, output, 1: stage 0 accepts the beat this cycle.
REQ-008 The block SHALL have port in_ctrl, input, CTRL_W: control fields (reg_write, mem_to_reg, link, ...).
REQ-009 The block SHALL have port in_data, input, DATA_W: payload (alu_out, read_data, pc_plus_4, hi/lo, ...).
REQ-010 The block SHALL have port stall, input, 1: global freeze.
REQ-011 The block SHALL have port flush, input, 1: kill all in-flight beats.
REQ-012 The block SHALL have port out_valid, output, 1: last stage holds a valid beat.
REQ-013 The block SHALL have port out_ready, input, 1: downstream accepts this cycle.
REQ-014 The block SHALL have port out_ctrl, output, CTRL_W: last-stage control.
REQ-015 The block SHALL have port out_data, output, DATA_W: last-stage payload.
REQ-016 The block SHALL have port occupancy, output, $clog2(DEPTH+1): count of valid stages.

Function
REQ-017 Each stage i SHALL hold registers v[i], ctrl[i] and data[i]; out_* SHALL be driven directly from stage DEPTH-1 with no combinational path from inputs.
REQ-018 adv[DEPTH-1] SHALL equal out_ready; adv[i] SHALL equal !v[i+1] || adv[i+1], so bubbles collapse.
REQ-019 in_ready SHALL equal !stall && !flush && (!v[0] || adv[0]), evaluated combinationally in the same cycle.
REQ-020 When !stall && !flush and stage i loads (i>0: adv[i-1]... equivalently !v[i] || adv[i]), stage i SHALL take v/ctrl/data from stage i-1, and stage 0 SHALL take in_valid/in_ctrl/in_data.
REQ-021 A stage that does not load SHALL hold; a stage whose beat leaves without replacement SHALL clear v.
REQ-022 When no bubbles are present and out_ready=1, latency SHALL be DEPTH cycles from acceptance to out_valid, with throughput of 1 beat/cycle.
REQ-023 While stall=1 and flush=0, all stage registers SHALL hold, out_valid SHALL be forced to 0, and in_ready SHALL be 0.
REQ-024 flush=1 SHALL clear all v[i] and ctrl[i] to 0 at the next edge, hold data[i], and drop the input beat; flush SHALL take priority over stall.
REQ-025 A beat handed downstream in the same cycle as flush SHALL count as delivered, because out_valid and out_ready are sampled before the edge.
REQ-026 occupancy SHALL be registered, equal to popcount(v), and updated in the same edge as v: +1 on accept without exit, -1 on exit without accept, 0 on flush.
REQ-027 occupancy SHALL never exceed DEPTH, and out_valid=0 SHALL imply that v[DEPTH-1]=0 or stall=1.
REQ-028 With DEPTH=1, stall=0, flush=0 and in_valid=1 tied, the block SHALL be cycle-equivalent to a plain stage register with enable out_ready.

Reset
REQ-029 On rst_n=0, all v, ctrl, data and occupancy SHALL be cleared asynchronously, giving out_valid=0, out_ctrl=0, out_data=0 and occupancy=0.
REQ-030 in_ready SHALL be 0 while rst_n=0, and it SHALL reflect REQ-019 from the first edge after deassertion.
REQ-031 Reset asserted mid-transfer SHALL drop every in-flight beat with no partial output.

Structure
REQ-032 Package pipe_pkg SHALL hold the CTRL_W field offsets (REG_WRITE, MEM_TO_REG[2:0], LINK) and the default widths, shared by all inter-stage instances.
REQ-033 Sub-module pipe_slot (one stage: v, ctrl, data, load/clear/flush) SHALL be instantiated DEPTH times via generate.
REQ-034 Parameter legality (1<=DEPTH<=4, widths>0) SHALL be checked at elaboration.

Verification (DEPTH=3, DATA_W=32, CTRL_W=8)
REQ-035 The bench SHALL drive a stream with out_ready=1 and in_data=0x1,0x2,0x3,0x4 on consecutive cycles, and SHALL check that out_data=0x1..0x4 appears on cycles 3..6 with out_valid=1 and occupancy=3 in steady state.
REQ-036 The bench SHALL hold out_ready=0 for 5 cycles after 2 accepts, and SHALL check that in_ready=1 until occupancy=3, then 0, that the beats are held unchanged, and that on release order is preserved with 1 beat/cycle.
REQ-037 The bench SHALL pulse flush=1 with occupancy=3 and ctrl=0xFF, and SHALL check that occupancy=0, out_valid=0 and out_ctrl=0x00 next cycle, with out_data held.
REQ-038 The bench SHALL assert stall=1 and flush=1 together, and SHALL check that the flush result (occupancy=0) occurs, with in_ready=0 during that cycle.
REQ-039 The bench SHALL apply stall=1 for 4 cycles mid-stream, and SHALL check out_valid=0, in_ready=0 and unchanged stage contents, then resume with no loss or duplication.
REQ-040 The bench SHALL assert rst_n=0 asynchronously between edges with occupancy=2, and SHALL check that outputs clear immediately, occupancy=0, and that the first post-reset beat exits after 3 cycles.

Source files
------------

// File: rtl/pipe_pkg.sv
// Shared definitions for the inter-stage pipeline registers: default widths,
// the legal depth range and the bit offsets of the control fields that every
// stage carries.
package pipe_pkg;

    localparam int DEFAULT_DATA_W = 32;
    localparam int DEFAULT_CTRL_W = 8;
    localparam int MAX_DEPTH      = 4;

    // Control-field layout inside the CTRL_W-wide control word.
    localparam int CTRL_REG_WRITE      = 0;
    localparam int CTRL_MEM_TO_REG_LSB = 1;
    localparam int CTRL_MEM_TO_REG_W   = 3;
    localparam int CTRL_LINK           = 4;

    // Same layout as a packed struct (first member is the MSB).
    typedef struct packed {
        logic       link;
        logic [2:0] mem_to_reg;
        logic       reg_write;
    } ctrl_fields_t;

    // Width of a counter able to hold 0..depth.
    function automatic int occ_width(input int depth);
        return $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/pipe_stage_regs_if.sv
// Bundle of handshake, payload and pipeline-control signals between the
// pipeline register block and its neighbours.
//
// Handshake: a beat transfers on a cycle where valid and ready are both 1 at
// the rising edge. The sender keeps valid and the payload steady until that
// cycle; ready may depend combinationally on the receiver's state and on the
// stall/flush controls, but never on valid.
interface pipe_stage_regs_if #(
    parameter int DATA_W = pipe_pkg::DEFAULT_DATA_W,
    parameter int CTRL_W = pipe_pkg::DEFAULT_CTRL_W,
    parameter int DEPTH  = 1
);
    localparam int OCC_W = pipe_pkg::occ_width(DEPTH);

    logic              in_valid;
    logic              in_ready;
    logic [CTRL_W-1:0] in_ctrl;
    logic [DATA_W-1:0] in_data;
    logic              stall;
    logic              flush;
    logic              out_valid;
    logic              out_ready;
    logic [CTRL_W-1:0] out_ctrl;
    logic [DATA_W-1:0] out_data;
    logic [OCC_W-1:0]  occupancy;

    // Environment side: feeds beats in, takes beats out, drives the controls.
    modport master (
        output in_valid, in_ctrl, in_data, stall, flush, out_ready,
        input  in_ready, out_valid, out_ctrl, out_data, occupancy
    );

    // Pipeline register block side.
    modport slave (
        input  in_valid, in_ctrl, in_data, stall, flush, out_ready,
        output in_ready, out_valid, out_ctrl, out_data, occupancy
    );

endinterface

// File: rtl/pipe_slot.sv
// One pipeline stage: valid bit, control word and payload. Flush kills the
// beat and zeroes the control word but leaves the payload in place; stall
// freezes everything.
module pipe_slot #(
    parameter int DATA_W = 32,
    parameter int CTRL_W = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_stall,
    input  logic              i_flush,
    input  logic              i_load,
    input  logic              i_v,
    input  logic [CTRL_W-1:0] i_ctrl,
    input  logic [DATA_W-1:0] i_data,
    output logic              o_v,
    output logic [CTRL_W-1:0] o_ctrl,
    output logic [DATA_W-1:0] o_data
);

    logic              r_v;
    logic [CTRL_W-1:0] r_ctrl;
    logic [DATA_W-1:0] r_data;

    // Stage register: flush beats stall, stall beats load, otherwise hold.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_v    <= 1'b0;
            r_ctrl <= '0;
            r_data <= '0;
        end else if (i_flush) begin
            r_v    <= 1'b0;
            r_ctrl <= '0;
        end else if (!i_stall && i_load) begin
            r_v    <= i_v;
            r_ctrl <= i_ctrl;
            r_data <= i_data;
        end
    end

    assign o_v    = r_v;
    assign o_ctrl = r_ctrl;
    assign o_data = r_data;

endmodule

// File: rtl/pipe_stage_regs.sv
// DEPTH-deep chain of pipeline registers with valid/ready flow control,
// bubble collapsing, global stall and flush, and a registered count of the
// stages currently holding a valid beat.
module pipe_stage_regs
    import pipe_pkg::*;
#(
    parameter int DATA_W = DEFAULT_DATA_W,
    parameter int CTRL_W = DEFAULT_CTRL_W,
    parameter int DEPTH  = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    pipe_stage_regs_if.slave bus
);

    localparam int OCC_W = occ_width(DEPTH);

    generate
        if (DEPTH < 1 || DEPTH > MAX_DEPTH || DATA_W < 1 || CTRL_W < 1) begin : g_bad_params
            $error("pipe_stage_regs: illegal parameters DEPTH=%0d DATA_W=%0d CTRL_W=%0d",
                   DEPTH, DATA_W, CTRL_W);
        end
    endgenerate

    logic [DEPTH-1:0]  w_v;
    logic [CTRL_W-1:0] w_ctrl [DEPTH];
    logic [DATA_W-1:0] w_data [DEPTH];
    logic [DEPTH-1:0]  w_adv;
    logic [DEPTH-1:0]  w_load;
    logic              w_accept;
    logic              w_exit;
    logic [OCC_W-1:0]  r_occ;

    // A stage can pass its beat on when the stage after it is empty or can
    // itself pass on; a stage loads when it is empty or its beat moves on.
    always_comb begin
        w_adv            = '0;
        w_adv[DEPTH-1]   = bus.out_ready;
        for (int i = DEPTH - 2; i >= 0; i--) begin
            w_adv[i] = !w_v[i+1] || w_adv[i+1];
        end
        w_load = ~w_v | w_adv;
    end

    generate
        for (genvar gi = 0; gi < DEPTH; gi++) begin : g_slot
            logic              w_src_v;
            logic [CTRL_W-1:0] w_src_ctrl;
            logic [DATA_W-1:0] w_src_data;

            if (gi == 0) begin : g_head
                assign w_src_v    = bus.in_valid;
                assign w_src_ctrl = bus.in_ctrl;
                assign w_src_data = bus.in_data;
            end else begin : g_body
                assign w_src_v    = w_v[gi-1];
                assign w_src_ctrl = w_ctrl[gi-1];
                assign w_src_data = w_data[gi-1];
            end

            pipe_slot #(
                .DATA_W (DATA_W),
                .CTRL_W (CTRL_W)
            ) u_slot (
                .clk     (clk),
                .rst_n   (rst_n),
                .i_stall (bus.stall),
                .i_flush (bus.flush),
                .i_load  (w_load[gi]),
                .i_v     (w_src_v),
                .i_ctrl  (w_src_ctrl),
                .i_data  (w_src_data),
                .o_v     (w_v[gi]),
                .o_ctrl  (w_ctrl[gi]),
                .o_data  (w_data[gi])
            );
        end
    endgenerate

    // Held low during reset so nothing is accepted while the stages are cleared.
    assign bus.in_ready  = rst_n && !bus.stall && !bus.flush && w_load[0];

    // Outputs come straight from the last stage; stall only masks valid.
    assign bus.out_valid = w_v[DEPTH-1] && !bus.stall;
    assign bus.out_ctrl  = w_ctrl[DEPTH-1];
    assign bus.out_data  = w_data[DEPTH-1];

    // A delivery during flush still counts, but flush zeroes the count anyway.
    assign w_accept = bus.in_valid && bus.in_ready;
    assign w_exit   = w_v[DEPTH-1] && bus.out_ready && !bus.stall && !bus.flush;

    // Occupancy tracks the number of valid stages, moving on the same edge as v.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_occ <= '0;
        end else if (bus.flush) begin
            r_occ <= '0;
        end else if (w_accept && !w_exit) begin
            r_occ <= r_occ + OCC_W'(1);
        end else if (w_exit && !w_accept) begin
            r_occ <= r_occ - OCC_W'(1);
        end
    end

    assign bus.occupancy = r_occ;

endmodule

// File: tb/tb_pipe_stage_regs.sv
// Directed bench for pipe_stage_regs at DEPTH=3: a table of per-cycle inputs
// and hand-computed expectations, plus explicit reset sequences.
module tb_pipe_stage_regs;

    localparam int DATA_W = 32;
    localparam int CTRL_W = 8;
    localparam int DEPTH  = 3;
    localparam int NV     = 41;

    logic clk;
    logic rst_n;
    int   n_checks;
    int   n_errors;

    pipe_stage_regs_if #(.DATA_W(DATA_W), .CTRL_W(CTRL_W), .DEPTH(DEPTH)) bus ();

    pipe_stage_regs #(.DATA_W(DATA_W), .CTRL_W(CTRL_W), .DEPTH(DEPTH)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    // Clock and watchdog.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    typedef struct {
        logic        iv;
        logic [31:0] d;
        logic [7:0]  c;
        logic        st;
        logic        fl;
        logic        ordy;
        logic        e_ir;
        logic        e_ov;
        logic [31:0] e_od;
        logic [7:0]  e_oc;
        logic [1:0]  e_occ;
    } vec_t;

    vec_t vecs [NV];

    function automatic vec_t mk(input logic iv, input logic [31:0] d, input logic [7:0] c,
                                input logic st, input logic fl, input logic ordy,
                                input logic e_ir, input logic e_ov, input logic [31:0] e_od,
                                input logic [7:0] e_oc, input logic [1:0] e_occ);
        vec_t v;
        v.iv = iv; v.d = d; v.c = c; v.st = st; v.fl = fl; v.ordy = ordy;
        v.e_ir = e_ir; v.e_ov = e_ov; v.e_od = e_od; v.e_oc = e_oc; v.e_occ = e_occ;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic drive(input logic iv, input logic [31:0] d, input logic [7:0] c,
                         input logic st, input logic fl, input logic ordy);
        bus.in_valid  = iv;
        bus.in_data   = d;
        bus.in_ctrl   = c;
        bus.stall     = st;
        bus.flush     = fl;
        bus.out_ready = ordy;
    endtask

    task automatic check_outputs(input string tag, input logic e_ir, input logic e_ov,
                                 input logic [31:0] e_od, input logic [7:0] e_oc,
                                 input logic [1:0] e_occ);
        check({tag, ".in_ready"},  32'(bus.in_ready),  32'(e_ir));
        check({tag, ".out_valid"}, 32'(bus.out_valid), 32'(e_ov));
        check({tag, ".out_data"},  bus.out_data,       e_od);
        check({tag, ".out_ctrl"},  32'(bus.out_ctrl),  32'(e_oc));
        check({tag, ".occupancy"}, 32'(bus.occupancy), 32'(e_occ));
    endtask

    initial begin
        n_checks = 0;
        n_errors = 0;

        // Each row: inputs for one cycle, then the outputs seen in that cycle
        // before the edge (registered state from previous edges).
        //                iv  data   ctrl   st fl or   ir ov  out_data out_ctrl occ
        // streaming with out_ready=1: out_data 1..4 on cycles 3..6
        vecs[0]  = mk(1, 32'h1,  8'hA1, 0, 0, 1,  1, 0, 32'h0,  8'h00, 0);
        vecs[1]  = mk(1, 32'h2,  8'hA2, 0, 0, 1,  1, 0, 32'h0,  8'h00, 1);
        vecs[2]  = mk(1, 32'h3,  8'hA3, 0, 0, 1,  1, 0, 32'h0,  8'h00, 2);
        vecs[3]  = mk(1, 32'h4,  8'hA4, 0, 0, 1,  1, 1, 32'h1,  8'hA1, 3);
        vecs[4]  = mk(0, 32'h0,  8'h00, 0, 0, 1,  1, 1, 32'h2,  8'hA2, 3);
        vecs[5]  = mk(0, 32'h0,  8'h00, 0, 0, 1,  1, 1, 32'h3,  8'hA3, 2);
        vecs[6]  = mk(0, 32'h0,  8'h00, 0, 0, 1,  1, 1, 32'h4,  8'hA4, 1);
        vecs[7]  = mk(0, 32'h0,  8'h00, 0, 0, 1,  1, 0, 32'h0,  8'h00, 0);
        // backpressure: out_ready=0, fills to 3 then in_ready drops, beats held
        vecs[8]  = mk(1, 32'h11, 8'hB1, 0, 0, 0,  1, 0, 32'h0,  8'h00, 0);
        vecs[9]  = mk(1, 32'h12, 8'hB2, 0, 0, 0,  1, 0, 32'h0,  8'h00, 1);
        vecs[10] = mk(1, 32'h13, 8'hB3, 0, 0, 0,  1, 0, 32'h0,  8'h00, 2);
        vecs[11] = mk(1, 32'h14, 8'hB4, 0, 0, 0,  0, 1, 32'h11, 8'hB1, 3);
        vecs[12] = mk(1, 32'h14, 8'hB4, 0, 0, 0,  0, 1, 32'h11, 8'hB1, 3);
        vecs[13] = mk(1, 32'h14, 8'hB4, 0, 0, 0,  0, 1, 32'h11, 8'hB1, 3);
        vecs[14] = mk(1, 32'h14, 8'hB4, 0, 0, 0,  0, 1, 32'h11, 8'hB1, 3);
        vecs[15] = mk(1, 32'h14, 8'hB4, 0, 0, 1,  1, 1, 32'h11, 8'hB1, 3);
        vecs[16] = mk(0, 32'h0,  8'h00, 0, 0, 1,  1, 1, 32'h12, 8'hB2, 3);
        vecs[17] = mk(0, 32'h0,  8'h00, 0, 0, 1,  1, 1, 32'h13, 8'hB3, 2);
        vecs[18] = mk(0, 32'h0,  8'h00, 0, 0, 1,  1, 1, 32'h14, 8'hB4, 1);
        vecs[19] = mk(0, 32'h0,  8'h00, 0, 0, 1,  1, 0, 32'h0,  8'h00, 0);
        // flush with three beats of ctrl=FF: v/ctrl cleared, data held
        vecs[20] = mk(1, 32'h21, 8'hFF, 0, 0, 0,  1, 0, 32'h0,  8'h00, 0);
        vecs[21] = mk(1, 32'h22, 8'hFF, 0, 0, 0,  1, 0, 32'h0,  8'h00, 1);
        vecs[22] = mk(1, 32'h23, 8'hFF, 0, 0, 0,  1, 0, 32'h0,  8'h00, 2);
        vecs[23] = mk(1, 32'h24, 8'hFF, 0, 1, 0,  0, 1, 32'h21, 8'hFF, 3);
        vecs[24] = mk(0, 32'h0,  8'h00, 0, 0, 0,  1, 0, 32'h21, 8'h00, 0);
        // stall and flush together: flush wins
        vecs[25] = mk(1, 32'h31, 8'hC1, 0, 0, 0,  1, 0, 32'h22, 8'h00, 0);
        vecs[26] = mk(1, 32'h32, 8'hC2, 0, 0, 0,  1, 0, 32'h23, 8'h00, 1);
        vecs[27] = mk(1, 32'h33, 8'hC3, 1, 1, 0,  0, 0, 32'h0,  8'h00, 2);
        vecs[28] = mk(0, 32'h0,  8'h00, 0, 0, 1,  1, 0, 32'h0,  8'h00, 0);
        // four-cycle stall mid-stream, then resume without loss or duplication
        vecs[29] = mk(1, 32'h41, 8'hD1, 0, 0, 1,  1, 0, 32'h31, 8'h00, 0);
        vecs[30] = mk(1, 32'h42, 8'hD2, 0, 0, 1,  1, 0, 32'h32, 8'h00, 1);
        vecs[31] = mk(1, 32'h43, 8'hD3, 0, 0, 1,  1, 0, 32'h0,  8'h00, 2);
        vecs[32] = mk(1, 32'h44, 8'hD4, 1, 0, 1,  0, 0, 32'h41, 8'hD1, 3);
        vecs[33] = mk(1, 32'h44, 8'hD4, 1, 0, 1,  0, 0, 32'h41, 8'hD1, 3);
        vecs[34] = mk(1, 32'h44, 8'hD4, 1, 0, 1,  0, 0, 32'h41, 8'hD1, 3);
        vecs[35] = mk(1, 32'h44, 8'hD4, 1, 0, 1,  0, 0, 32'h41, 8'hD1, 3);
        vecs[36] = mk(1, 32'h44, 8'hD4, 0, 0, 1,  1, 1, 32'h41, 8'hD1, 3);
        vecs[37] = mk(0, 32'h0,  8'h00, 0, 0, 1,  1, 1, 32'h42, 8'hD2, 3);
        vecs[38] = mk(0, 32'h0,  8'h00, 0, 0, 1,  1, 1, 32'h43, 8'hD3, 2);
        vecs[39] = mk(0, 32'h0,  8'h00, 0, 0, 1,  1, 1, 32'h44, 8'hD4, 1);
        vecs[40] = mk(0, 32'h0,  8'h00, 0, 0, 1,  1, 0, 32'h0,  8'h00, 0);

        // Reset state, with in_valid high to show in_ready stays low.
        rst_n = 1'b0;
        drive(1, 32'h0, 8'h00, 0, 0, 1);
        #12;
        check_outputs("reset", 0, 0, 32'h0, 8'h00, 0);
        drive(0, 32'h0, 8'h00, 0, 0, 1);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Table-driven cycles.
        for (int k = 0; k < NV; k++) begin
            drive(vecs[k].iv, vecs[k].d, vecs[k].c, vecs[k].st, vecs[k].fl, vecs[k].ordy);
            #1;
            check_outputs($sformatf("v%0d", k), vecs[k].e_ir, vecs[k].e_ov,
                          vecs[k].e_od, vecs[k].e_oc, vecs[k].e_occ);
            @(posedge clk);
            #1;
        end

        // Asynchronous reset between edges with two beats in flight.
        drive(1, 32'h51, 8'hE1, 0, 0, 1);
        @(posedge clk); #1;
        drive(1, 32'h52, 8'hE2, 0, 0, 1);
        @(posedge clk); #1;
        drive(1, 32'h53, 8'hE3, 0, 0, 1);
        @(posedge clk); #1;
        drive(0, 32'h0, 8'h00, 0, 0, 1);
        @(posedge clk); #1;
        check("pre_rst.occupancy", 32'(bus.occupancy), 32'd2);
        check("pre_rst.out_data",  bus.out_data,       32'h52);
        drive(0, 32'h0, 8'h00, 0, 0, 0);
        #2;
        rst_n = 1'b0;
        #1;
        check_outputs("async_rst", 0, 0, 32'h0, 8'h00, 0);
        @(posedge clk); #1;
        check_outputs("in_rst", 0, 0, 32'h0, 8'h00, 0);

        // First beat after reset exits after three cycles; nothing else follows.
        @(negedge clk);
        rst_n = 1'b1;
        drive(1, 32'h61, 8'hF1, 0, 0, 1);
        #1;
        check("post_rst.in_ready", 32'(bus.in_ready), 32'd1);
        @(posedge clk); #1;
        drive(0, 32'h0, 8'h00, 0, 0, 1);
        check("post_rst.c1.out_valid", 32'(bus.out_valid), 32'd0);
        @(posedge clk); #1;
        check("post_rst.c2.out_valid", 32'(bus.out_valid), 32'd0);
        @(posedge clk); #1;
        check("post_rst.c3.out_valid", 32'(bus.out_valid), 32'd1);
        check("post_rst.c3.out_data",  bus.out_data,       32'h61);
        check("post_rst.c3.out_ctrl",  32'(bus.out_ctrl),  32'hF1);
        check("post_rst.c3.occupancy", 32'(bus.occupancy), 32'd1);
        @(posedge clk); #1;
        check("post_rst.c4.out_valid", 32'(bus.out_valid), 32'd0);
        check("post_rst.c4.occupancy", 32'(bus.occupancy), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
